// File: rtl/chroma_qam_encoder.sv
`default_nettype none
// chroma_qam_encoder: DDS carrier, burst sequencer, PAL V-switch and saturating QAM chroma.
// Rev 1.0 - parametrised widths, LUT depth and burst length.
module chroma_qam_encoder #(
    parameter int IN_WIDTH    = 6,
    parameter int OUT_WIDTH   = 8,
    parameter int PHASE_WIDTH = 32,
    parameter int LUT_ADDR    = 8,
    parameter int SIN_WIDTH   = 8,
    parameter int BURST_LEN   = 36
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pal_mode,
    input  logic        [PHASE_WIDTH-1:0] phase_inc,
    input  logic                          newframe,
    input  logic                          newline,
    input  logic                          startburst,
    input  logic                          active,
    input  logic signed [IN_WIDTH-1:0]    yuv_u,
    input  logic signed [IN_WIDTH-1:0]    yuv_v,
    input  logic signed [IN_WIDTH-1:0]    burst_amp,
    output logic signed [OUT_WIDTH-1:0]   chroma,
    output logic                          burst_active
);
    localparam int  LUT_SIZE = 1 << LUT_ADDR;
    localparam int  OP_W     = IN_WIDTH + 1;
    localparam int  PROD_W   = IN_WIDTH + SIN_WIDTH + 1;
    localparam int  SUM_W    = PROD_W + 1;
    localparam int  CNT_W    = $clog2(BURST_LEN + 1);
    localparam real PEAK     = real'((1 << (SIN_WIDTH - 1)) - 1);
    localparam real TWO_PI   = 6.283185307179586;
    localparam logic signed [SUM_W-1:0] ROUND = SUM_W'(1 << (SIN_WIDTH - 2));
    localparam logic signed [SUM_W-1:0] MAXV  = SUM_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MINV  = SUM_W'(-(1 << (OUT_WIDTH - 1)));

    // Sine table built at elaboration; int'() of a real rounds to nearest.
    logic signed [SIN_WIDTH-1:0] lut [LUT_SIZE];
    for (genvar k = 0; k < LUT_SIZE; k++) begin : g_lut
        localparam int VAL = int'(PEAK * $sin(TWO_PI * real'(k) / real'(LUT_SIZE)));
        assign lut[k] = SIN_WIDTH'(VAL);
    end

    typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, VIDEO = 2'd2} state_t;
    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [PHASE_WIDTH-1:0] acc;
    logic                   vswitch;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            vswitch <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
        end else begin
            acc     <= newframe ? '0 : acc + phase_inc;
            if (newframe)     vswitch <= 1'b0;
            else if (newline) vswitch <= ~vswitch;
            state   <= state_nx;
            cnt     <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (startburst) begin
                    state_nx = BURST;
                    cnt_nx   = '0;
                end else if (active) begin
                    state_nx = VIDEO;
                end
            end
            BURST: begin
                if (startburst) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_W'(BURST_LEN - 1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            VIDEO: begin
                if (startburst) begin
                    state_nx = BURST;
                    cnt_nx   = '0;
                end else if (!active) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // One extra bit so -(-2^(IN_WIDTH-1)) stays representable.
    logic signed [OP_W-1:0] amp_ext, amp_neg, op_u, op_v;
    assign amp_ext = {burst_amp[IN_WIDTH-1], burst_amp};
    assign amp_neg = -amp_ext;

    always_comb begin
        op_u = '0;
        op_v = '0;
        case (state)
            BURST: begin
                op_u = amp_neg;
                op_v = pal_mode ? amp_ext : '0;
            end
            VIDEO: begin
                op_u = {yuv_u[IN_WIDTH-1], yuv_u};
                op_v = {yuv_v[IN_WIDTH-1], yuv_v};
            end
            default: ;
        endcase
    end

    logic [LUT_ADDR-1:0] addr, addr_cos;
    assign addr     = acc[PHASE_WIDTH-1 -: LUT_ADDR];
    assign addr_cos = addr + LUT_ADDR'(LUT_SIZE / 4);

    logic signed [OP_W-1:0]      s1_u, s1_v;
    logic signed [SIN_WIDTH-1:0] s1_sin, s1_cos;
    logic                        s1_neg, s1_burst;
    logic signed [PROD_W-1:0]    s2_pu, s2_pv;
    logic                        s2_burst;

    logic signed [PROD_W-1:0] u_x, v_x, sin_x, cos_x, prod_u, prod_v;
    assign u_x    = PROD_W'(s1_u);
    assign v_x    = PROD_W'(s1_v);
    assign sin_x  = PROD_W'(s1_sin);
    assign cos_x  = PROD_W'(s1_cos);
    assign prod_u = u_x * cos_x;
    assign prod_v = v_x * sin_x;

    logic signed [SUM_W-1:0] sum, shifted;
    assign sum     = SUM_W'(s2_pu) + SUM_W'(s2_pv) + ROUND;
    assign shifted = sum >>> (SIN_WIDTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_u         <= '0;
            s1_v         <= '0;
            s1_sin       <= '0;
            s1_cos       <= '0;
            s1_neg       <= 1'b0;
            s1_burst     <= 1'b0;
            s2_pu        <= '0;
            s2_pv        <= '0;
            s2_burst     <= 1'b0;
            chroma       <= '0;
            burst_active <= 1'b0;
        end else begin
            s1_u         <= op_u;
            s1_v         <= op_v;
            s1_sin       <= lut[addr];
            s1_cos       <= lut[addr_cos];
            s1_neg       <= pal_mode & vswitch;
            s1_burst     <= (state == BURST);
            s2_pu        <= prod_u;
            s2_pv        <= s1_neg ? -prod_v : prod_v;
            s2_burst     <= s1_burst;
            if (shifted > MAXV)      chroma <= MAXV[OUT_WIDTH-1:0];
            else if (shifted < MINV) chroma <= MINV[OUT_WIDTH-1:0];
            else                     chroma <= shifted[OUT_WIDTH-1:0];
            burst_active <= s2_burst;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_chroma_qam_encoder.sv
`default_nettype none
// Bench for chroma_qam_encoder: segment table checked through a scoreboard, plus
// hand-checked sequences for carrier phase, burst timing, saturation and mid-burst reset.
module tb_chroma_qam_encoder;
    logic clk = 1'b0;
    logic rst, pal_mode, newframe, newline, startburst, active;
    logic        [31:0] phase_inc;
    logic signed [5:0]  yuv_u, yuv_v, burst_amp;
    logic signed [7:0]  chroma8;
    logic signed [4:0]  chroma5;
    logic               burst8, burst5;

    always #5 clk = ~clk;

    chroma_qam_encoder #(.OUT_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .pal_mode(pal_mode), .phase_inc(phase_inc),
        .newframe(newframe), .newline(newline), .startburst(startburst), .active(active),
        .yuv_u(yuv_u), .yuv_v(yuv_v), .burst_amp(burst_amp),
        .chroma(chroma8), .burst_active(burst8));

    chroma_qam_encoder #(.OUT_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .pal_mode(pal_mode), .phase_inc(phase_inc),
        .newframe(newframe), .newline(newline), .startburst(startburst), .active(active),
        .yuv_u(yuv_u), .yuv_v(yuv_v), .burst_amp(burst_amp),
        .chroma(chroma5), .burst_active(burst5));

    typedef struct { int c8; int c5; int b; } exp_t;
    typedef struct {
        bit rst; bit pal; bit nf; bit nl; bit sb; bit act;
        logic [31:0] inc; int u; int v; int a; int n;
    } seg_t;

    exp_t q[$];
    int   n_vec = 0, n_err = 0, cyc = 0;
    int   hist8 [4096];
    int   hist5 [4096];
    int   histb [4096];
    int   lut   [256];

    logic [31:0] m_acc;
    bit          m_vsw;
    int          m_state, m_cnt;

    function automatic int sat(int x, int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    task automatic chk(string name, int act_v, int exp_v);
        n_vec++;
        if (act_v != exp_v) begin
            n_err++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act_v, exp_v);
        end
    endtask

    task automatic cycle();
        exp_t e;
        int   u, v, a, idx, pu, pv, s;
        bit   was_rst;
        was_rst = rst;
        if (!rst) begin
            a = int'(burst_amp);
            u = 0; v = 0;
            if (m_state == 1) begin u = -a; v = pal_mode ? a : 0; end
            else if (m_state == 2) begin u = int'(yuv_u); v = int'(yuv_v); end
            idx = int'(m_acc[31:24]);
            pu = u * lut[(idx + 64) % 256];
            pv = v * lut[idx];
            if (pal_mode && m_vsw) pv = -pv;
            s = (pu + pv + 64) >>> 7;
            e.c8 = sat(s, 8);
            e.c5 = sat(s, 5);
            e.b  = (m_state == 1) ? 1 : 0;
            q.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            m_acc = '0; m_vsw = 0; m_state = 0; m_cnt = 0;
        end else begin
            if (newframe) begin m_acc = '0; m_vsw = 0; end
            else begin
                m_acc = m_acc + phase_inc;
                if (newline) m_vsw = !m_vsw;
            end
            case (m_state)
                0: if (startburst) begin m_state = 1; m_cnt = 0; end
                   else if (active) m_state = 2;
                1: if (startburst) m_cnt = 0;
                   else if (m_cnt == 35) begin m_state = 0; m_cnt = 0; end
                   else m_cnt++;
                default: if (startburst) begin m_state = 1; m_cnt = 0; end
                         else if (!active) m_state = 0;
            endcase
        end
        @(negedge clk);
        if (was_rst) begin
            q.delete();
            e.c8 = 0; e.c5 = 0; e.b = 0;
            q.push_back(e);
            q.push_back(e);
            chk("rst_chroma8", int'(chroma8), 0);
            chk("rst_chroma5", int'(chroma5), 0);
            chk("rst_burst",   int'(burst8),  0);
        end else begin
            e = q.pop_front();
            chk("chroma8", int'(chroma8), e.c8);
            chk("chroma5", int'(chroma5), e.c5);
            chk("burst8",  int'(burst8),  e.b);
            chk("burst5",  int'(burst5),  e.b);
        end
        if (cyc < 4096) begin
            hist8[cyc] = int'(chroma8);
            hist5[cyc] = int'(chroma5);
            histb[cyc] = int'(burst8);
        end
        cyc++;
    endtask

    task automatic run_seg(seg_t sg);
        rst        = sg.rst;
        pal_mode   = sg.pal;
        newframe   = sg.nf;
        newline    = sg.nl;
        startburst = sg.sb;
        active     = sg.act;
        phase_inc  = sg.inc;
        yuv_u      = 6'(sg.u);
        yuv_v      = 6'(sg.v);
        burst_amp  = 6'(sg.a);
        cycle();
        newframe = 0; newline = 0; startburst = 0;
        repeat (sg.n - 1) cycle();
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) cycle();
        rst = 0;
    endtask

    seg_t tbl [12];
    int   base, cnt_b;
    int   e8 [4];
    int   e5 [4];
    int   eb [4];

    initial begin
        for (int k = 0; k < 256; k++)
            lut[k] = int'(127.0 * $sin(6.283185307179586 * real'(k) / 256.0));
        rst = 1; pal_mode = 0; newframe = 0; newline = 0; startburst = 0; active = 0;
        phase_inc = '0; yuv_u = '0; yuv_v = '0; burst_amp = '0;

        //           rst pal nf nl sb act inc            u    v    a    n
        tbl[0]  = '{1,  0,  0, 0, 0, 0,  32'h0,         0,   0,   0,   2};
        tbl[1]  = '{0,  0,  1, 0, 0, 1,  32'h4000_0000, 31,  0,   0,   8};
        tbl[2]  = '{0,  1,  1, 0, 0, 1,  32'h4000_0000, 0,   31,  0,   8};
        tbl[3]  = '{0,  1,  0, 1, 0, 1,  32'h4000_0000, 0,   31,  0,   8};
        tbl[4]  = '{0,  1,  1, 0, 0, 1,  32'h4000_0000, 0,   31,  0,   8};
        tbl[5]  = '{0,  1,  1, 1, 0, 1,  32'h4000_0000, -32, -32, 0,   8};
        tbl[6]  = '{0,  0,  0, 0, 1, 1,  32'h4000_0000, 10,  -7,  20,  45};
        tbl[7]  = '{0,  1,  0, 1, 1, 0,  32'h0123_4567, 5,   5,   -32, 45};
        tbl[8]  = '{0,  0,  0, 0, 0, 1,  32'h0,         -32, 31,  0,   6};
        tbl[9]  = '{0,  1,  0, 0, 1, 1,  32'h1999_999A, 12,  -20, 31,  10};
        tbl[10] = '{1,  1,  0, 0, 0, 1,  32'h1999_999A, 12,  -20, 31,  1};
        tbl[11] = '{0,  1,  0, 1, 0, 1,  32'h1999_999A, 31,  -32, 31,  12};
        for (int i = 0; i < 12; i++) run_seg(tbl[i]);

        // Carrier at fs/4: 31,0,-31,0 on the 8-bit output, clipped to 15/-16 on the 5-bit one.
        do_reset();
        base = cyc;
        pal_mode = 0; phase_inc = 32'h4000_0000; newframe = 1; active = 1;
        yuv_u = 6'sd31; yuv_v = '0;
        cycle();
        newframe = 0;
        repeat (7) cycle();
        e8 = '{31, 0, -31, 0};
        e5 = '{15, 0, -16, 0};
        for (int k = 0; k < 4; k++) begin
            chk("t1_chroma8", hist8[base + 3 + k], e8[k]);
            chk("t4_chroma5", hist5[base + 3 + k], e5[k]);
        end

        // NTSC burst: exactly BURST_LEN flagged samples, phase -A*cos.
        do_reset();
        base = cyc;
        active = 0; burst_amp = 6'sd20; newframe = 1;
        cycle();
        newframe = 0; startburst = 1;
        cycle();
        startburst = 0;
        repeat (44) cycle();
        cnt_b = 0;
        for (int k = 0; k < 46; k++) cnt_b += histb[base + k];
        chk("t2_burst_len", cnt_b, 36);
        e8 = '{0, 20, 0, -20};
        eb = '{0, 1, 1, 0};
        for (int k = 0; k < 4; k++) chk("t2_burst_chroma", hist8[base + 4 + k], e8[k]);
        chk("t2_burst_first", histb[base + 3], eb[0]);
        chk("t2_burst_on",    histb[base + 4], eb[1]);
        chk("t2_burst_last",  histb[base + 39], eb[2]);
        chk("t2_burst_off",   histb[base + 40], eb[3]);
        chk("t2_after_burst", hist8[base + 41], 0);

        // Reset in the middle of a PAL burst flushes the pipeline at once.
        do_reset();
        pal_mode = 1; burst_amp = 6'sd25; active = 1; startburst = 1;
        cycle();
        startburst = 0;
        repeat (10) cycle();
        rst = 1;
        cycle();
        rst = 0; active = 0;
        base = cyc;
        repeat (4) cycle();
        for (int k = 0; k < 4; k++) begin
            chk("t6_chroma_flushed", hist8[base + k], 0);
            chk("t6_burst_flushed",  histb[base + k], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
